// File: rtl/lsf_heg_arbiter.sv
// Round-robin arbiter that lends one LSF datapath (ROI + hit write ports) to NUM_HEG hit-extraction groups.
// Optional build macro LSF_ARB_EOF_FLUSH_EN: i_eof restarts the round-robin at HEG 0 for the next frame.

module lsf_heg_lane #(
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             roi_ph_i,
  input  logic             hit_ph_i,
  input  logic             hit_af_i,
  output logic             roi_rdy_o,
  output logic             hit_rdy_o
);
  logic mine;
  assign mine      = (sel_i == SEL_W'(IDX));
  assign roi_rdy_o = mine & roi_ph_i;
  assign hit_rdy_o = mine & hit_ph_i & ~hit_af_i;
endmodule

module lsf_heg_arbiter #(
  parameter int NUM_HEG        = 3,
  parameter int ROI_W          = 32,
  parameter int HIT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_HEG*ROI_W-1:0] i_roi,
  input  logic [NUM_HEG-1:0]       i_roi_valid,
  input  logic [NUM_HEG-1:0]       i_roi_nohit,
  output logic [NUM_HEG-1:0]       o_roi_ready,
  input  logic [NUM_HEG*HIT_W-1:0] i_hit,
  input  logic [NUM_HEG-1:0]       i_hit_valid,
  input  logic [NUM_HEG-1:0]       i_hit_last,
  output logic [NUM_HEG-1:0]       o_hit_ready,
  input  logic                     i_hit_af,
  output logic [ROI_W-1:0]         o_roi,
  output logic                     o_roi_we,
  output logic [HIT_W-1:0]         o_hit,
  output logic                     o_hit_we,
  input  logic                     i_lsf_done,
  input  logic                     i_eof,
  output logic [2:0]               o_sel,
  output logic                     o_busy,
  output logic                     o_timeout,
  output logic [15:0]              o_timeout_cnt
);
  localparam int SEL_W = (NUM_HEG > 1) ? $clog2(NUM_HEG) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SEND_ROI, SEND_HITS, WAIT_LSF} state_e;

  state_e           state_q;
  logic [SEL_W-1:0] sel_q, last_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ROI_W-1:0] roi_q;
  logic [HIT_W-1:0] hit_q;
  logic             roi_we_q, hit_we_q, to_q;
  logic [15:0]      to_cnt_q;

  logic [NUM_HEG-1:0][ROI_W-1:0] roi_arr;
  logic [NUM_HEG-1:0][HIT_W-1:0] hit_arr;
  assign roi_arr = i_roi;
  assign hit_arr = i_hit;

  logic flush;
`ifdef LSF_ARB_EOF_FLUSH_EN
  logic eof_pend_q;
  assign flush = eof_pend_q | i_eof;
  // Pending EOF is consumed in IDLE, so an in-flight ROI always completes first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                eof_pend_q <= 1'b0;
    else if (state_q == IDLE) eof_pend_q <= 1'b0;
    else if (i_eof)           eof_pend_q <= 1'b1;
  end
`else
  logic unused_eof;
  assign unused_eof = i_eof;
  assign flush      = 1'b0;
`endif

  logic [SEL_W-1:0] base_d, gnt_d, idx_c;
  logic [SEL_W:0]   sum_c;
  logic             any_req;
  assign base_d = flush ? SEL_W'(NUM_HEG - 1) : last_q;

  // Scan farthest-first so the nearest requester after base_d wins the final overwrite.
  always_comb begin
    gnt_d   = base_d;
    any_req = 1'b0;
    sum_c   = '0;
    idx_c   = '0;
    for (int i = NUM_HEG; i >= 1; i--) begin
      sum_c = {1'b0, base_d} + (SEL_W+1)'(i);
      if (sum_c >= (SEL_W+1)'(NUM_HEG)) sum_c = sum_c - (SEL_W+1)'(NUM_HEG);
      idx_c = sum_c[SEL_W-1:0];
      if (i_roi_valid[idx_c]) begin
        gnt_d   = idx_c;
        any_req = 1'b1;
      end
    end
  end

  logic roi_ph, hit_ph, hit_acc;
  assign roi_ph  = (state_q == SEND_ROI);
  assign hit_ph  = (state_q == SEND_HITS);
  assign hit_acc = |(o_hit_ready & i_hit_valid);

  for (genvar k = 0; k < NUM_HEG; k++) begin : g_lane
    lsf_heg_lane #(.SEL_W(SEL_W), .IDX(k)) u_lane (
      .sel_i     (sel_q),
      .roi_ph_i  (roi_ph),
      .hit_ph_i  (hit_ph),
      .hit_af_i  (i_hit_af),
      .roi_rdy_o (o_roi_ready[k]),
      .hit_rdy_o (o_hit_ready[k])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      last_q   <= SEL_W'(NUM_HEG - 1);
      cnt_q    <= '0;
      roi_q    <= '0;
      hit_q    <= '0;
      roi_we_q <= 1'b0;
      hit_we_q <= 1'b0;
      to_q     <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      roi_we_q <= 1'b0;
      hit_we_q <= 1'b0;
      to_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush) last_q <= SEL_W'(NUM_HEG - 1);
          if (any_req) begin
            sel_q   <= gnt_d;
            last_q  <= gnt_d;
            state_q <= SEND_ROI;
          end
        end
        SEND_ROI: begin
          roi_q    <= roi_arr[sel_q];
          roi_we_q <= 1'b1;
          cnt_q    <= '0;
          state_q  <= i_roi_nohit[sel_q] ? WAIT_LSF : SEND_HITS;
        end
        SEND_HITS: begin
          if (hit_acc) begin
            hit_q    <= hit_arr[sel_q];
            hit_we_q <= 1'b1;
            if (i_hit_last[sel_q]) begin
              cnt_q   <= '0;
              state_q <= WAIT_LSF;
            end
          end
        end
        WAIT_LSF: begin
          // A result arriving on the expiry cycle still counts as a normal completion.
          if (i_lsf_done) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q <= IDLE;
            to_q    <= 1'b1;
            if (to_cnt_q != 16'hFFFF) to_cnt_q <= to_cnt_q + 16'd1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_sel            = '0;
    o_sel[SEL_W-1:0] = sel_q;
  end

  assign o_roi         = roi_q;
  assign o_roi_we      = roi_we_q;
  assign o_hit         = hit_q;
  assign o_hit_we      = hit_we_q;
  assign o_busy        = (state_q != IDLE);
  assign o_timeout     = to_q;
  assign o_timeout_cnt = to_cnt_q;
endmodule
